ul4_checker: RTL and testbench

- Response-side companion to the 4-bit logic unit ul4: consumes a stream of applied vectors (A, B, S) together with the ul4 result Out, and checks each against the golden function.
- Counts vectors and mismatches, captures the first failing vector, and compacts all results into a 16-bit MISR signature.
- Sits at the ul4 output in the self-test datapath, opposite the stimulus generator that sweeps all 1024 (B,A,S) combinations.

---
 rtl/ul4_checker.sv | 127 ++++++++++++
 tb/tb_ul4_checker.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ul4_checker.sv
// Response checker for the 4-bit logic unit ul4. It compares each applied (a, b, s)
// vector against the golden function, counts vectors and errors, and compacts results into a MISR.
module ul4_checker #(
  parameter int          NUM_VECTORS = 1024,        // legal range 1..1024
  parameter logic [15:0] MISR_SEED   = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  a,
  input  logic [3:0]  b,
  input  logic [1:0]  s,
  input  logic [3:0]  out,
  output logic        done,
  output logic        pass,
  output logic [10:0] vec_count,
  output logic [10:0] err_count,
  output logic [9:0]  first_fail_idx,
  output logic [13:0] first_fail_vec,
  output logic [15:0] signature
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [10:0] LAST_COUNT = 11'(NUM_VECTORS);

  state_e      state_q, state_d;
  logic [10:0] vec_q, vec_d;
  logic [10:0] err_q, err_d;
  logic [9:0]  ffi_q, ffi_d;
  logic [13:0] ffv_q, ffv_d;
  logic [15:0] sig_q, sig_d;

  logic [3:0]  golden;
  logic        mismatch;
  logic        misr_fb;

  always_comb begin
    unique case (s)
      2'b00:   golden = a & b;
      2'b01:   golden = a | b;
      2'b10:   golden = a ^ b;
      default: golden = ~a;
    endcase
  end

  assign mismatch = (out != golden);
  assign misr_fb  = sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3];

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    ffi_d   = ffi_q;
    ffv_d   = ffv_q;
    sig_d   = sig_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          vec_d   = '0;
          err_d   = '0;
          ffi_d   = '0;
          ffv_d   = '0;
          sig_d   = MISR_SEED;
        end
      end
      RUN: begin
        if (start) begin
          // A restart wins over a transfer presented in the same cycle.
          vec_d = '0;
          err_d = '0;
          ffi_d = '0;
          ffv_d = '0;
          sig_d = MISR_SEED;
        end else if (in_valid) begin
          vec_d = vec_q + 11'd1;
          sig_d = {sig_q[14:0], misr_fb} ^ {12'b0, out};
          if (mismatch) begin
            // err_q == 0 marks the first failure; saturation keeps it nonzero afterwards.
            if (err_q == 11'd0) begin
              ffi_d = vec_q[9:0];
              ffv_d = {b, a, s, out};
            end
            if (err_q != '1) err_d = err_q + 11'd1;
          end
          if (vec_d == LAST_COUNT) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      ffi_q   <= '0;
      ffv_q   <= '0;
      sig_q   <= MISR_SEED;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      ffi_q   <= ffi_d;
      ffv_q   <= ffv_d;
      sig_q   <= sig_d;
    end
  end

  // Every output decodes registered state only; no input reaches an output combinationally.
  assign in_ready       = (state_q == RUN);
  assign done           = (state_q == DONE);
  assign pass           = (state_q == DONE) && (err_q == 11'd0);
  assign vec_count      = vec_q;
  assign err_count      = err_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_vec = ffv_q;
  assign signature      = sig_q;

endmodule

// File: tb/tb_ul4_checker.sv
// Bench for ul4_checker: directed sweeps plus randomized traffic, checked against
// a behavioural model that works from the golden function and MISR recurrence.
module tb_ul4_checker;

  logic        clk = 1'b0;
  logic        reset, start, start1, in_valid;
  logic [3:0]  a, b, out;
  logic [1:0]  s;

  logic        in_ready, done, pass;
  logic [10:0] vec_count, err_count;
  logic [9:0]  first_fail_idx;
  logic [13:0] first_fail_vec;
  logic [15:0] signature;

  logic        in_ready1, done1, pass1;
  logic [10:0] vec_count1, err_count1;
  logic [9:0]  first_fail_idx1;
  logic [13:0] first_fail_vec1;
  logic [15:0] signature1;

  int n_cmp = 0;
  int n_bad = 0;

  int m_vec, m_err, m_ffi, m_ffv, m_sig;
  int clean_sig;

  always #5 clk = ~clk;

  ul4_checker dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .s(s), .out(out), .done(done), .pass(pass),
    .vec_count(vec_count), .err_count(err_count), .first_fail_idx(first_fail_idx),
    .first_fail_vec(first_fail_vec), .signature(signature)
  );

  ul4_checker #(.NUM_VECTORS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .s(s), .out(out), .done(done1), .pass(pass1),
    .vec_count(vec_count1), .err_count(err_count1), .first_fail_idx(first_fail_idx1),
    .first_fail_vec(first_fail_vec1), .signature(signature1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] golden_fn(input logic [3:0] ga, input logic [3:0] gb,
                                           input logic [1:0] gs);
    case (gs)
      2'd0:    return ga & gb;
      2'd1:    return ga | gb;
      2'd2:    return ga ^ gb;
      default: return ~ga;
    endcase
  endfunction

  // Shift left by one, feed back the parity of taps 15,14,12,3, then fold in the result nibble.
  function automatic int misr_next(input int sg, input logic [3:0] o);
    int fb;
    fb = $countones(sg & 32'hD008) % 2;
    return (((sg * 2) % 65536) + fb) ^ int'(o);
  endfunction

  task automatic model_clear();
    m_vec = 0; m_err = 0; m_ffi = 0; m_ffv = 0; m_sig = 'hFFFF;
  endtask

  task automatic model_xfer(input logic [3:0] ma, input logic [3:0] mb,
                            input logic [1:0] ms, input logic [3:0] mo);
    if (mo !== golden_fn(ma, mb, ms)) begin
      if (m_err == 0) begin
        m_ffi = m_vec;
        m_ffv = int'({mb, ma, ms, mo});
      end
      if (m_err < 2047) m_err++;
    end
    m_vec++;
    m_sig = misr_next(m_sig, mo);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
  endtask

  task automatic send(input logic [3:0] va, input logic [3:0] vb,
                      input logic [1:0] vs, input logic [3:0] vo);
    a = va; b = vb; s = vs; out = vo; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    model_xfer(va, vb, vs, vo);
  endtask

  // Sweep order: index bits [1:0]=S, [5:2]=A, [9:6]=B. bad1 forces out=0, bad2 inverts out.
  task automatic sweep(input int bad1, input int bad2, input int stall_at, input int limit);
    logic [9:0] iv;
    logic [3:0] o;
    for (int i = 0; i < limit; i++) begin
      iv = i[9:0];
      if (i == stall_at) begin
        for (int k = 0; k < 7; k++) begin
          tick();
          chk("stall_vec_count", vec_count, 32'(stall_at));
        end
      end
      o = golden_fn(iv[5:2], iv[9:6], iv[1:0]);
      if (i == bad1) o = 4'h0;
      else if (i == bad2) o = ~o;
      if (i == 1023) chk("done_before_last", done, 0);
      send(iv[5:2], iv[9:6], iv[1:0], o);
    end
  endtask

  task automatic check_final(input string tag);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_pass"}, pass, (m_err == 0) ? 1 : 0);
    chk({tag, "_vec"}, vec_count, m_vec);
    chk({tag, "_err"}, err_count, m_err);
    chk({tag, "_ffi"}, first_fail_idx, m_ffi);
    chk({tag, "_ffv"}, first_fail_vec, m_ffv);
    chk({tag, "_sig"}, signature, m_sig);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start1 = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; s = '0; out = '0;
    model_clear();
    tick(); tick();
    chk("rst_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_vec", vec_count, 0);
    chk("rst_err", err_count, 0);
    chk("rst_ffi", first_fail_idx, 0);
    chk("rst_ffv", first_fail_vec, 0);
    chk("rst_sig", signature, 16'hFFFF);
    chk("rst_ready1", in_ready1, 0);
    reset = 1'b0;

    // Vectors presented in IDLE are ignored.
    send(4'h3, 4'h5, 2'd0, 4'hF);
    model_clear();
    chk("idle_ignore_vec", vec_count, 0);
    chk("idle_ignore_sig", signature, 16'hFFFF);

    // Clean sweep.
    do_start();
    chk("run_ready", in_ready, 1);
    sweep(-1, -1, -1, 1024);
    check_final("clean");
    chk("clean_vec_const", vec_count, 1024);
    chk("clean_pass_const", pass, 1);
    clean_sig = m_sig;

    // Results hold in DONE even with traffic presented.
    for (int k = 0; k < 3; k++) begin
      a = 4'($urandom); b = 4'($urandom); s = 2'($urandom); out = 4'($urandom);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check_final("done_hold");

    // Single error at vector 5.
    do_start();
    chk("restart_done_clr", done, 0);
    chk("restart_vec_clr", vec_count, 0);
    sweep(5, -1, -1, 1024);
    check_final("err1");
    chk("err1_err_const", err_count, 1);
    chk("err1_ffi_const", first_fail_idx, 5);
    chk("err1_ffv_const", first_fail_vec, 14'b0000_0001_01_0000);

    // Errors at vectors 5 and 9.
    do_start();
    sweep(5, 9, -1, 1024);
    check_final("err2");
    chk("err2_err_const", err_count, 2);
    chk("err2_ffi_const", first_fail_idx, 5);

    // Seven-cycle stall mid-run.
    do_start();
    sweep(-1, -1, 500, 1024);
    check_final("stall");
    chk("stall_sig_clean", signature, clean_sig);

    // Reset aborts a run after 300 transfers.
    do_start();
    sweep(-1, -1, -1, 300);
    chk("pre_abort_vec", vec_count, 300);
    reset = 1'b1;
    tick();
    chk("abort_done", done, 0);
    chk("abort_ready", in_ready, 0);
    chk("abort_vec", vec_count, 0);
    chk("abort_sig", signature, 16'hFFFF);
    reset = 1'b0;
    do_start();
    sweep(-1, -1, -1, 1024);
    check_final("post_abort");
    chk("post_abort_sig_clean", signature, clean_sig);

    // start during RUN restarts and discards the coincident transfer.
    do_start();
    sweep(-1, -1, -1, 10);
    a = 4'h1; b = 4'h2; s = 2'd2; out = 4'h0; in_valid = 1'b1; start = 1'b1;
    tick();
    in_valid = 1'b0; start = 1'b0;
    model_clear();
    chk("rerun_vec", vec_count, 0);
    chk("rerun_sig", signature, 16'hFFFF);
    chk("rerun_ready", in_ready, 1);

    // Randomized traffic with random stalls and random corruption.
    while (m_vec < 1024) begin
      if ($urandom_range(3) == 0) begin
        in_valid = 1'b0;
        tick();
        chk("rand_idle_vec", vec_count, m_vec);
      end else begin
        logic [3:0] ra, rb, ro;
        logic [1:0] rs;
        ra = 4'($urandom); rb = 4'($urandom); rs = 2'($urandom);
        ro = golden_fn(ra, rb, rs);
        if ($urandom_range(7) == 0) ro = 4'($urandom);
        send(ra, rb, rs, ro);
        if (m_vec % 128 == 0) begin
          chk("rand_vec", vec_count, m_vec);
          chk("rand_err", err_count, m_err);
          chk("rand_sig", signature, m_sig);
        end
      end
    end
    check_final("rand");

    // NUM_VECTORS=1 instance: a failing run, then a passing rerun from DONE.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("n1_ready", in_ready1, 1);
    send(4'h6, 4'h3, 2'd0, 4'h0);
    chk("n1_done", done1, 1);
    chk("n1_pass_fail", pass1, 0);
    chk("n1_vec", vec_count1, 1);
    chk("n1_ffi", first_fail_idx1, 0);
    chk("n1_ffv", first_fail_vec1, {4'h3, 4'h6, 2'd0, 4'h0});
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("n1_restart_done", done1, 0);
    chk("n1_restart_err", err_count1, 0);
    send(4'b1010, 4'h7, 2'd3, 4'b0101);
    chk("n1_done2", done1, 1);
    chk("n1_pass2", pass1, 1);
    chk("n1_vec2", vec_count1, 1);
    chk("n1_ready2", in_ready1, 0);
    chk("n1_sig2", signature1, misr_next('hFFFF, 4'b0101));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
